// File: rtl/alu_pkg.sv
// Shared definitions for the two-client ALU arbiter: opcodes, default width, FSM states.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    PASS0 = 3'd0,
    PASS1 = 3'd1,
    ADD   = 3'd2,
    AND   = 3'd3,
    XOR   = 3'd4,
    PASSB = 3'd5,
    PASS6 = 3'd6,
    PASS7 = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_2.sv
// Shared combinational ALU: every PASSn opcode other than PASSB forwards A.
// a_is_zero flags an all-zero ALU output.
module alu_2
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic             a_is_zero
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch can be inferred.
    alu_out = a;
    case (alu_op_e'(op))
      ADD:     alu_out = a + b;
      AND:     alu_out = a & b;
      XOR:     alu_out = a ^ b;
      PASSB:   alu_out = b;
      default: alu_out = a;
    endcase
    a_is_zero = (alu_out == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two clients (IDLE -> EXEC -> DONE).
// Optional grant statistics counters are built only when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             busy,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
);

  state_e           state_q, state_d;
  logic             last_q, last_d;    // last winner, 1 = client 1
  logic             owner_q, owner_d;  // client whose operation is in EXEC
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             win;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  alu_2 #(.WIDTH(WIDTH)) u_alu (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .alu_out   (alu_out),
    .a_is_zero (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    // A tie goes to the client that did not win last; a lone requester always wins.
    win      = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE, DONE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          owner_d = win;
          last_d  = win;
          op_d    = win ? op1 : op0;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_out;
        zero_d   = alu_zero;
        state_d  = DONE;
        done0_d  = ~owner_q;
        done1_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign result      = result_q;
  assign result_zero = zero_q;
  assign busy        = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Counters saturate rather than wrap so a long run never reports a small count.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0_d && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (gnt1_d && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule
